aes_subbytes_shiftrows: RTL and testbench

Iterative AES SubBytes + ShiftRows stage that sits directly upstream of top_aes_mixcolumns and feeds its state0..state3 inputs. It uses the same start/done handshake and column-word interface as top_aes_mixcolumns. It processes one byte per clock through a single S-box, trading latency (16 cycles) for area. It applies ShiftRows by writing each substituted byte into its shifted position.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_sbox.sv | 47 ++++
 rtl/aes_subbytes_shiftrows.sv | 103 ++++++++++
 tb/tb_aes_subbytes_shiftrows.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding for the iterative
// SubBytes/ShiftRows stage, and the ShiftRows byte-position mapping.
package aes_pkg;

    localparam int AES_NB          = 4;
    localparam int AES_STATE_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sbsr_state_t;

    // Byte index k = 4*c + r; ShiftRows moves row r left by r columns.
    function automatic logic [3:0] shift_rows_dst(input logic [3:0] src);
        logic [1:0] row;
        logic [1:0] col;
        row = src[1:0];
        col = src[3:2] - src[1:0];
        return {col, row};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a flat 256-entry lookup, purely combinational so it
// can be shared with key expansion without adding latency.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (a)
            8'h00: y = 8'h63; 8'h01: y = 8'h7c; 8'h02: y = 8'h77; 8'h03: y = 8'h7b; 8'h04: y = 8'hf2; 8'h05: y = 8'h6b; 8'h06: y = 8'h6f; 8'h07: y = 8'hc5;
            8'h08: y = 8'h30; 8'h09: y = 8'h01; 8'h0a: y = 8'h67; 8'h0b: y = 8'h2b; 8'h0c: y = 8'hfe; 8'h0d: y = 8'hd7; 8'h0e: y = 8'hab; 8'h0f: y = 8'h76;
            8'h10: y = 8'hca; 8'h11: y = 8'h82; 8'h12: y = 8'hc9; 8'h13: y = 8'h7d; 8'h14: y = 8'hfa; 8'h15: y = 8'h59; 8'h16: y = 8'h47; 8'h17: y = 8'hf0;
            8'h18: y = 8'had; 8'h19: y = 8'hd4; 8'h1a: y = 8'ha2; 8'h1b: y = 8'haf; 8'h1c: y = 8'h9c; 8'h1d: y = 8'ha4; 8'h1e: y = 8'h72; 8'h1f: y = 8'hc0;
            8'h20: y = 8'hb7; 8'h21: y = 8'hfd; 8'h22: y = 8'h93; 8'h23: y = 8'h26; 8'h24: y = 8'h36; 8'h25: y = 8'h3f; 8'h26: y = 8'hf7; 8'h27: y = 8'hcc;
            8'h28: y = 8'h34; 8'h29: y = 8'ha5; 8'h2a: y = 8'he5; 8'h2b: y = 8'hf1; 8'h2c: y = 8'h71; 8'h2d: y = 8'hd8; 8'h2e: y = 8'h31; 8'h2f: y = 8'h15;
            8'h30: y = 8'h04; 8'h31: y = 8'hc7; 8'h32: y = 8'h23; 8'h33: y = 8'hc3; 8'h34: y = 8'h18; 8'h35: y = 8'h96; 8'h36: y = 8'h05; 8'h37: y = 8'h9a;
            8'h38: y = 8'h07; 8'h39: y = 8'h12; 8'h3a: y = 8'h80; 8'h3b: y = 8'he2; 8'h3c: y = 8'heb; 8'h3d: y = 8'h27; 8'h3e: y = 8'hb2; 8'h3f: y = 8'h75;
            8'h40: y = 8'h09; 8'h41: y = 8'h83; 8'h42: y = 8'h2c; 8'h43: y = 8'h1a; 8'h44: y = 8'h1b; 8'h45: y = 8'h6e; 8'h46: y = 8'h5a; 8'h47: y = 8'ha0;
            8'h48: y = 8'h52; 8'h49: y = 8'h3b; 8'h4a: y = 8'hd6; 8'h4b: y = 8'hb3; 8'h4c: y = 8'h29; 8'h4d: y = 8'he3; 8'h4e: y = 8'h2f; 8'h4f: y = 8'h84;
            8'h50: y = 8'h53; 8'h51: y = 8'hd1; 8'h52: y = 8'h00; 8'h53: y = 8'hed; 8'h54: y = 8'h20; 8'h55: y = 8'hfc; 8'h56: y = 8'hb1; 8'h57: y = 8'h5b;
            8'h58: y = 8'h6a; 8'h59: y = 8'hcb; 8'h5a: y = 8'hbe; 8'h5b: y = 8'h39; 8'h5c: y = 8'h4a; 8'h5d: y = 8'h4c; 8'h5e: y = 8'h58; 8'h5f: y = 8'hcf;
            8'h60: y = 8'hd0; 8'h61: y = 8'hef; 8'h62: y = 8'haa; 8'h63: y = 8'hfb; 8'h64: y = 8'h43; 8'h65: y = 8'h4d; 8'h66: y = 8'h33; 8'h67: y = 8'h85;
            8'h68: y = 8'h45; 8'h69: y = 8'hf9; 8'h6a: y = 8'h02; 8'h6b: y = 8'h7f; 8'h6c: y = 8'h50; 8'h6d: y = 8'h3c; 8'h6e: y = 8'h9f; 8'h6f: y = 8'ha8;
            8'h70: y = 8'h51; 8'h71: y = 8'ha3; 8'h72: y = 8'h40; 8'h73: y = 8'h8f; 8'h74: y = 8'h92; 8'h75: y = 8'h9d; 8'h76: y = 8'h38; 8'h77: y = 8'hf5;
            8'h78: y = 8'hbc; 8'h79: y = 8'hb6; 8'h7a: y = 8'hda; 8'h7b: y = 8'h21; 8'h7c: y = 8'h10; 8'h7d: y = 8'hff; 8'h7e: y = 8'hf3; 8'h7f: y = 8'hd2;
            8'h80: y = 8'hcd; 8'h81: y = 8'h0c; 8'h82: y = 8'h13; 8'h83: y = 8'hec; 8'h84: y = 8'h5f; 8'h85: y = 8'h97; 8'h86: y = 8'h44; 8'h87: y = 8'h17;
            8'h88: y = 8'hc4; 8'h89: y = 8'ha7; 8'h8a: y = 8'h7e; 8'h8b: y = 8'h3d; 8'h8c: y = 8'h64; 8'h8d: y = 8'h5d; 8'h8e: y = 8'h19; 8'h8f: y = 8'h73;
            8'h90: y = 8'h60; 8'h91: y = 8'h81; 8'h92: y = 8'h4f; 8'h93: y = 8'hdc; 8'h94: y = 8'h22; 8'h95: y = 8'h2a; 8'h96: y = 8'h90; 8'h97: y = 8'h88;
            8'h98: y = 8'h46; 8'h99: y = 8'hee; 8'h9a: y = 8'hb8; 8'h9b: y = 8'h14; 8'h9c: y = 8'hde; 8'h9d: y = 8'h5e; 8'h9e: y = 8'h0b; 8'h9f: y = 8'hdb;
            8'ha0: y = 8'he0; 8'ha1: y = 8'h32; 8'ha2: y = 8'h3a; 8'ha3: y = 8'h0a; 8'ha4: y = 8'h49; 8'ha5: y = 8'h06; 8'ha6: y = 8'h24; 8'ha7: y = 8'h5c;
            8'ha8: y = 8'hc2; 8'ha9: y = 8'hd3; 8'haa: y = 8'hac; 8'hab: y = 8'h62; 8'hac: y = 8'h91; 8'had: y = 8'h95; 8'hae: y = 8'he4; 8'haf: y = 8'h79;
            8'hb0: y = 8'he7; 8'hb1: y = 8'hc8; 8'hb2: y = 8'h37; 8'hb3: y = 8'h6d; 8'hb4: y = 8'h8d; 8'hb5: y = 8'hd5; 8'hb6: y = 8'h4e; 8'hb7: y = 8'ha9;
            8'hb8: y = 8'h6c; 8'hb9: y = 8'h56; 8'hba: y = 8'hf4; 8'hbb: y = 8'hea; 8'hbc: y = 8'h65; 8'hbd: y = 8'h7a; 8'hbe: y = 8'hae; 8'hbf: y = 8'h08;
            8'hc0: y = 8'hba; 8'hc1: y = 8'h78; 8'hc2: y = 8'h25; 8'hc3: y = 8'h2e; 8'hc4: y = 8'h1c; 8'hc5: y = 8'ha6; 8'hc6: y = 8'hb4; 8'hc7: y = 8'hc6;
            8'hc8: y = 8'he8; 8'hc9: y = 8'hdd; 8'hca: y = 8'h74; 8'hcb: y = 8'h1f; 8'hcc: y = 8'h4b; 8'hcd: y = 8'hbd; 8'hce: y = 8'h8b; 8'hcf: y = 8'h8a;
            8'hd0: y = 8'h70; 8'hd1: y = 8'h3e; 8'hd2: y = 8'hb5; 8'hd3: y = 8'h66; 8'hd4: y = 8'h48; 8'hd5: y = 8'h03; 8'hd6: y = 8'hf6; 8'hd7: y = 8'h0e;
            8'hd8: y = 8'h61; 8'hd9: y = 8'h35; 8'hda: y = 8'h57; 8'hdb: y = 8'hb9; 8'hdc: y = 8'h86; 8'hdd: y = 8'hc1; 8'hde: y = 8'h1d; 8'hdf: y = 8'h9e;
            8'he0: y = 8'he1; 8'he1: y = 8'hf8; 8'he2: y = 8'h98; 8'he3: y = 8'h11; 8'he4: y = 8'h69; 8'he5: y = 8'hd9; 8'he6: y = 8'h8e; 8'he7: y = 8'h94;
            8'he8: y = 8'h9b; 8'he9: y = 8'h1e; 8'hea: y = 8'h87; 8'heb: y = 8'he9; 8'hec: y = 8'hce; 8'hed: y = 8'h55; 8'hee: y = 8'h28; 8'hef: y = 8'hdf;
            8'hf0: y = 8'h8c; 8'hf1: y = 8'ha1; 8'hf2: y = 8'h89; 8'hf3: y = 8'h0d; 8'hf4: y = 8'hbf; 8'hf5: y = 8'he6; 8'hf6: y = 8'h42; 8'hf7: y = 8'h68;
            8'hf8: y = 8'h41; 8'hf9: y = 8'h99; 8'hfa: y = 8'h2d; 8'hfb: y = 8'h0f; 8'hfc: y = 8'hb0; 8'hfd: y = 8'h54; 8'hfe: y = 8'hbb; 8'hff: y = 8'h16;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_subbytes_shiftrows.sv
// Iterative SubBytes + ShiftRows: one byte per clock through a single S-box,
// each substituted byte written straight into its row-shifted position.
module aes_subbytes_shiftrows
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] state0,
    input  logic [31:0] state1,
    input  logic [31:0] state2,
    input  logic [31:0] state3,
    output logic [31:0] state_out0,
    output logic [31:0] state_out1,
    output logic [31:0] state_out2,
    output logic [31:0] state_out3,
    output logic        busy,
    output logic        done
);

    sbsr_state_t state;
    logic [3:0]  cnt;
    logic [7:0]  in_buf    [AES_STATE_BYTES];
    logic [7:0]  work_buf  [AES_STATE_BYTES];
    logic [7:0]  work_next [AES_STATE_BYTES];
    logic [31:0] state_in  [AES_NB];
    logic [31:0] result_word [AES_NB];
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;

    assign state_in[0] = state0;
    assign state_in[1] = state1;
    assign state_in[2] = state2;
    assign state_in[3] = state3;

    assign sbox_in = in_buf[cnt];

    aes_sbox u_sbox (
        .a (sbox_in),
        .y (sbox_out)
    );

    // The final copy to the outputs must include the byte substituted this cycle.
    always_comb begin
        work_next = work_buf;
        work_next[shift_rows_dst(cnt)] = sbox_out;
        for (int c = 0; c < AES_NB; c++) begin
            result_word[c] = {work_next[4*c], work_next[4*c+1],
                              work_next[4*c+2], work_next[4*c+3]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_out0 <= 32'h0;
            state_out1 <= 32'h0;
            state_out2 <= 32'h0;
            state_out3 <= 32'h0;
            for (int k = 0; k < AES_STATE_BYTES; k++) begin
                in_buf[k]   <= 8'h00;
                work_buf[k] <= 8'h00;
            end
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts a new start the same way IDLE does for back-to-back use.
                IDLE, DONE: begin
                    if (start) begin
                        for (int c = 0; c < AES_NB; c++) begin
                            for (int r = 0; r < 4; r++) begin
                                in_buf[4*c+r] <= state_in[c][31-8*r -: 8];
                            end
                        end
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work_buf <= work_next;
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'(AES_STATE_BYTES - 1)) begin
                        state_out0 <= result_word[0];
                        state_out1 <= result_word[1];
                        state_out2 <= result_word[2];
                        state_out3 <= result_word[3];
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_subbytes_shiftrows.sv
// Self-checking bench: fixed FIPS-197 vectors, handshake corner cases and
// random states against a reference built from GF(2^8) inversion + affine map.
module tb_aes_subbytes_shiftrows;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] state0 = 32'h0, state1 = 32'h0, state2 = 32'h0, state3 = 32'h0;
    logic [31:0] state_out0, state_out1, state_out2, state_out3;
    logic        busy, done;
    logic [127:0] dut_out;

    int check_count = 0;
    int error_count = 0;
    logic [7:0] sbox_tab [256];

    aes_subbytes_shiftrows dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .state0     (state0),
        .state1     (state1),
        .state2     (state2),
        .state3     (state3),
        .state_out0 (state_out0),
        .state_out1 (state_out1),
        .state_out2 (state_out2),
        .state_out3 (state_out3),
        .busy       (busy),
        .done       (done)
    );

    assign dut_out = {state_out0, state_out1, state_out2, state_out3};

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gf_mul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Column c, row r lives at bits [127-32c-8r -: 8] of the packed state.
    function automatic logic [127:0] model(input logic [127:0] in);
        logic [127:0] res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int dc = (c - r + 4) % 4;
                res[127-32*dc-8*r -: 8] = sbox_tab[in[127-32*c-8*r -: 8]];
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveState(input logic [127:0] v);
        {state0, state1, state2, state3} = v;
    endtask

    // Called #1 after the edge that sampled start; returns #1 after done is seen.
    task automatic waitDone(input logic [127:0] poke_val, input int poke_cycle,
                            output int cycles, output int busy_cnt, output bit held);
        logic [127:0] entry_out = dut_out;
        cycles   = 0;
        busy_cnt = busy ? 1 : 0;
        held     = 1'b1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            if (!done) begin
                if (busy) busy_cnt++;
                if (dut_out !== entry_out) held = 1'b0;
                if (cycles == poke_cycle) begin
                    driveState(poke_val);
                    start = 1'b1;
                end
            end
        end
        if (!done) checkOutput("done_timeout", 128'(done), 128'd1);
    endtask

    task automatic applyStimulus(input string tag, input logic [127:0] in,
                                 input logic [127:0] poke_val, input int poke_cycle,
                                 input bit check_pulse);
        int cycles, busy_cnt;
        bit held;
        @(negedge clk);
        driveState(in);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(poke_val, poke_cycle, cycles, busy_cnt, held);
        checkOutput({tag, "_latency"}, 128'(cycles), 128'd16);
        checkOutput({tag, "_busy_cycles"}, 128'(busy_cnt), 128'd16);
        checkOutput({tag, "_held"}, 128'(held), 128'd1);
        checkOutput({tag, "_result"}, dut_out, model(in));
        if (check_pulse) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_done_one_cycle"}, 128'(done), 128'd0);
            checkOutput({tag, "_busy_after"}, 128'(busy), 128'd0);
            checkOutput({tag, "_result_stable"}, dut_out, model(in));
        end
    endtask

    localparam logic [127:0] APPB_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] POS_IN   = 128'h00000000_01010101_02020202_03030303;
    localparam logic [127:0] POS_OUT  = 128'h637c777b_7c777b63_777b637c_7b637c77;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got hang expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        logic [127:0] vec_a, vec_b;
        int cycles, busy_cnt, done_seen;
        bit held;

        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", dut_out, 128'h0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("appb", APPB_IN, '0, -1, 1'b1);
        checkOutput("appb_const", dut_out, APPB_OUT);

        applyStimulus("position", POS_IN, '0, -1, 1'b1);
        checkOutput("position_const", dut_out, POS_OUT);

        applyStimulus("zero", 128'h0, '0, -1, 1'b1);
        checkOutput("zero_const", dut_out, {4{32'h63636363}});

        // Restart attempt during RUN must be ignored; new inputs stay on the pins.
        vec_a = {$urandom, $urandom, $urandom, $urandom};
        vec_b = ~vec_a;
        applyStimulus("repulse", vec_a, vec_b, 4, 1'b1);
        repeat (20) begin
            @(posedge clk);
            #1;
            checkOutput("repulse_no_second_done", 128'(done), 128'd0);
        end

        // Back-to-back: start held during the DONE cycle.
        vec_a = {$urandom, $urandom, $urandom, $urandom};
        vec_b = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus("b2b_first", vec_a, '0, -1, 1'b0);
        driveState(vec_b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy_restart", 128'(busy), 128'd1);
        checkOutput("b2b_first_held", dut_out, model(vec_a));
        waitDone('0, -1, cycles, busy_cnt, held);
        checkOutput("b2b_latency", 128'(cycles), 128'd16);
        checkOutput("b2b_held", 128'(held), 128'd1);
        checkOutput("b2b_second_result", dut_out, model(vec_b));
        @(posedge clk);
        #1;
        checkOutput("b2b_done_one_cycle", 128'(done), 128'd0);

        // Reset during RUN aborts: no done, outputs cleared.
        @(negedge clk);
        driveState(POS_IN);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_out", dut_out, 128'h0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_done", 128'(done), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", 128'(done_seen), 128'd0);
        checkOutput("abort_out_idle", dut_out, 128'h0);
        applyStimulus("after_abort", APPB_IN, '0, -1, 1'b1);
        checkOutput("after_abort_const", dut_out, APPB_OUT);

        for (int n = 0; n < 12; n++) begin
            vec_a = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus($sformatf("random%0d", n), vec_a, '0, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
